// File: rtl/stereo_pkg.sv
// stereo_pkg: shared geometry, derived widths, FSM states and lane packing for the stereo pipeline
package stereo_pkg;
  localparam int WIN = 15;
  localparam int DATA_SIZE = 8;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int MAX_DISP = 64;
  localparam int COL_BITS = $clog2(IMG_W);
  localparam int ROW_BITS = $clog2(IMG_H);
  localparam int DISP_BITS = $clog2(MAX_DISP);
  localparam int SAD_BITS = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;
  function automatic int lane_lsb(input int k, input int dsize);
    return dsize * k;
  endfunction
  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction
endpackage

// File: rtl/stereo_row_mem.sv
// stereo_row_mem: WIN-1 circular row slots, one write per cycle, read-first registered read of all slots
module stereo_row_mem #(
  parameter int WIN = stereo_pkg::WIN,
  parameter int DATA_SIZE = stereo_pkg::DATA_SIZE,
  parameter int IMG_W = stereo_pkg::IMG_W,
  parameter int COL_BITS = stereo_pkg::COL_BITS,
  parameter int SLOT_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_we,
  input  logic                           i_re,
  input  logic [SLOT_BITS-1:0]           i_slot,
  input  logic [COL_BITS-1:0]            i_addr,
  input  logic [DATA_SIZE-1:0]           i_wdata,
  output logic [(WIN-1)*DATA_SIZE-1:0]   o_lanes
);
  import stereo_pkg::*;
  logic [DATA_SIZE-1:0] r_mem [WIN-1][IMG_W];
  logic [(WIN-1)*DATA_SIZE-1:0] r_lanes;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_slot][i_addr] <= i_wdata;
  // lane 0 is the slot being overwritten this cycle, i.e. the oldest row
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lanes <= '0;
    else if (i_re)
      for (int k = 0; k < WIN - 1; k++)
        r_lanes[lane_lsb(k, DATA_SIZE) +: DATA_SIZE] <= r_mem[SLOT_BITS'(wrap_idx(int'(i_slot) + k, WIN - 1))][i_addr];
  assign o_lanes = r_lanes;
endmodule

// File: rtl/stereo_line_buffer.sv
// stereo_line_buffer: raster L/R pixel stream to WIN-tall column slices for the disparity engine
module stereo_line_buffer #(
  parameter int WIN = stereo_pkg::WIN,
  parameter int DATA_SIZE = stereo_pkg::DATA_SIZE,
  parameter int IMG_W = stereo_pkg::IMG_W,
  parameter int IMG_H = stereo_pkg::IMG_H,
  parameter int COL_BITS = stereo_pkg::COL_BITS,
  parameter int ROW_BITS = stereo_pkg::ROW_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [DATA_SIZE-1:0]     in_pix_L,
  input  logic [DATA_SIZE-1:0]     in_pix_R,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_SIZE*WIN-1:0] out_col_L,
  output logic [DATA_SIZE*WIN-1:0] out_col_R,
  output logic [COL_BITS-1:0]      out_col_idx,
  output logic [ROW_BITS-1:0]      out_row_idx,
  output logic                     out_eol,
  output logic                     out_eof
);
  import stereo_pkg::*;
  localparam int SLOT_BITS = (WIN > 2) ? $clog2(WIN - 1) : 1;
  localparam int HALF = (WIN - 1) / 2;
  state_t r_state, w_state_nx;
  logic [COL_BITS-1:0] r_col, w_col, w_col_nx;
  logic [ROW_BITS-1:0] r_row, w_row, w_row_nx;
  logic [SLOT_BITS-1:0] r_slot, w_slot, w_slot_nx;
  logic [DATA_SIZE-1:0] r_pix_L, r_pix_R;
  logic [(WIN-1)*DATA_SIZE-1:0] w_lanes_L, w_lanes_R;
  logic w_acc, w_sof, w_we, w_emit, w_eol, w_last;
  assign in_ready = !out_valid || out_ready;
  assign w_acc = in_valid && in_ready;
  assign w_sof = w_acc && in_sof;
  // an accepted sof restarts the frame at slot 0 / row 0 / col 0 in any state
  always_comb begin
    w_col = w_sof ? '0 : r_col;
    w_row = w_sof ? '0 : r_row;
    w_slot = w_sof ? '0 : r_slot;
    w_we = w_sof || (w_acc && r_state != S_IDLE);
    w_emit = w_acc && !in_sof && r_state == S_STREAM;
    w_eol = w_col == COL_BITS'(IMG_W - 1);
    w_last = w_eol && w_row == ROW_BITS'(IMG_H - 1);
    w_col_nx = w_eol ? '0 : w_col + COL_BITS'(1);
    w_row_nx = w_eol ? w_row + ROW_BITS'(1) : w_row;
    w_slot_nx = !w_eol ? w_slot : (w_slot == SLOT_BITS'(WIN - 2)) ? '0 : w_slot + SLOT_BITS'(1);
    w_state_nx = w_sof ? S_PRIME :
                 (w_acc && r_state == S_PRIME && w_eol && w_row_nx == ROW_BITS'(WIN - 1)) ? S_STREAM :
                 (w_emit && w_last) ? S_IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_col <= '0;
      r_row <= '0;
      r_slot <= '0;
      r_pix_L <= '0;
      r_pix_R <= '0;
      out_valid <= 1'b0;
      out_col_idx <= '0;
      out_row_idx <= '0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_we) begin
        r_col <= w_col_nx;
        r_row <= w_row_nx;
        r_slot <= w_slot_nx;
      end
      if (in_ready) out_valid <= w_emit;
      if (w_emit) begin
        r_pix_L <= in_pix_L;
        r_pix_R <= in_pix_R;
        out_col_idx <= w_col;
        out_row_idx <= w_row - ROW_BITS'(HALF);
        out_eol <= w_eol;
        out_eof <= w_last;
      end
    end
  stereo_row_mem #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .COL_BITS(COL_BITS), .SLOT_BITS(SLOT_BITS)) u_mem_l (
    .clk(clk), .rst(rst), .i_we(w_we), .i_re(w_emit), .i_slot(w_slot), .i_addr(w_col), .i_wdata(in_pix_L), .o_lanes(w_lanes_L)
  );
  stereo_row_mem #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .COL_BITS(COL_BITS), .SLOT_BITS(SLOT_BITS)) u_mem_r (
    .clk(clk), .rst(rst), .i_we(w_we), .i_re(w_emit), .i_slot(w_slot), .i_addr(w_col), .i_wdata(in_pix_R), .o_lanes(w_lanes_R)
  );
  assign out_col_L = {r_pix_L, w_lanes_L};
  assign out_col_R = {r_pix_R, w_lanes_R};
endmodule

// File: tb/tb_stereo_line_buffer.sv
// tb_stereo_line_buffer: directed checks of priming, slicing, backpressure, sof abort and async reset
module tb_stereo_line_buffer;
  localparam int WIN = 3, D = 8, W = 4, H = 5, CB = 2, RB = 3;
  logic clk = 0, rst = 0, in_valid = 0, in_sof = 0, out_ready = 1;
  logic [D-1:0] in_pix_L = 0, in_pix_R = 0;
  logic in_ready, out_valid, out_eol, out_eof;
  logic [D*WIN-1:0] out_col_L, out_col_R;
  logic [CB-1:0] out_col_idx;
  logic [RB-1:0] out_row_idx;
  int checks = 0, passes = 0, fails = 0, nslices = 0;
  always #5 clk = ~clk;
  stereo_line_buffer #(.WIN(WIN), .DATA_SIZE(D), .IMG_W(W), .IMG_H(H), .COL_BITS(CB), .ROW_BITS(RB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_pix_L(in_pix_L), .in_pix_R(in_pix_R), .out_valid(out_valid), .out_ready(out_ready),
    .out_col_L(out_col_L), .out_col_R(out_col_R), .out_col_idx(out_col_idx),
    .out_row_idx(out_row_idx), .out_eol(out_eol), .out_eof(out_eof)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [D-1:0] pix(input int base, input int r, input int c);
    return D'(base + r * 16 + c);
  endfunction
  function automatic logic [D*WIN-1:0] lanes(input int base, input int r, input int c);
    return {pix(base, r, c), pix(base, r - 1, c), pix(base, r - 2, c)};
  endfunction
  task automatic check_slice(input string tag, input int base, input int r, input int c);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_col"}, out_col_idx, c);
    chk({tag, "_row"}, out_row_idx, r - 1);
    chk({tag, "_L"}, out_col_L, lanes(base, r, c));
    chk({tag, "_R"}, out_col_R, lanes(base + 1, r, c));
    chk({tag, "_eol"}, out_eol, c == W - 1);
    chk({tag, "_eof"}, out_eof, c == W - 1 && r == H - 1);
  endtask
  task automatic run_frame(input int base, input int nbeats, input int stall_at);
    nslices = 0;
    for (int i = 0; i < nbeats; i++) begin
      int r = i / W;
      int c = i % W;
      in_valid = 1;
      in_sof = (i == 0);
      in_pix_L = pix(base, r, c);
      in_pix_R = pix(base + 1, r, c);
      if (i == stall_at) begin
        out_ready = 0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("bp_in_ready", in_ready, 0);
          check_slice("bp_hold", base, (i - 1) / W, (i - 1) % W);
        end
        out_ready = 1;
      end
      tick();
      if (i < (WIN - 1) * W) chk("prime_quiet", out_valid, 0);
      else begin
        if (out_valid) nslices++;
        check_slice("slice", base, r, c);
      end
    end
    in_valid = 0;
    in_sof = 0;
  endtask
  task automatic drain();
    tick();
    chk("drain_quiet", out_valid, 0);
  endtask
  initial begin
    #2 rst = 1;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_L", out_col_L, 0);
    chk("rst_R", out_col_R, 0);
    chk("rst_col", out_col_idx, 0);
    chk("rst_row", out_row_idx, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_eof", out_eof, 0);
    rst = 0;
    tick();
    run_frame(0, W * H, -1);
    chk("full_count", nslices, (H - WIN + 1) * W);
    drain();
    run_frame(0, W * H, 13);
    chk("bp_count", nslices, (H - WIN + 1) * W);
    drain();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_sof = 0;
      in_pix_L = 8'hEE;
      in_pix_R = 8'hEF;
      tick();
      chk("presof_quiet", out_valid, 0);
    end
    run_frame(0, W * H, -1);
    chk("presof_count", nslices, (H - WIN + 1) * W);
    drain();
    run_frame(0, 13, -1);
    run_frame(8'h80, W * H, -1);
    chk("abort_count", nslices, (H - WIN + 1) * W);
    drain();
    run_frame(0, 11, -1);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    tick();
    rst = 0;
    tick();
    run_frame(0, W * H, -1);
    chk("arst_count", nslices, (H - WIN + 1) * W);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
